rect_raster_core: RTL and testbench
===================================

// Module: rect_raster_core
// PURPOSE
//  Per-pixel rectangle compositor: loads RECT_COUNT rectangles (x,y,w,h,color) from a word stream,
//  clamps them to screen space, then for each (x_coord,y_coord) returns the color of the highest-index
//  rectangle covering it, else DEFAULT_COLOR. Sits between the rect copy controller and the video output.
// PARAMETERS
//  COORD_WIDTH      10       screen coordinate width
//  RECT_COUNT       64       rectangles stored; power of two
//  RECT_COUNT_WIDTH 6        log2(RECT_COUNT)
//  DEFAULT_COLOR    16'h0000 background color when no rectangle hits
// PORTS
//  clk         in  1            single clock, rising edge
//  reset       in  1            asynchronous, active-high
//  copy_start  in  1            starts a rectangle load, sampled in WAIT only
//  x_coord     in  COORD_WIDTH  pixel x
//  y_coord     in  COORD_WIDTH  pixel y
//  mem_din     in  16           rect data stream, signed 16-bit words
//  ready       out 1            high in EXECUTE
//  color       out 16           pixel color
// BEHAVIOUR
//  Reset: state=WAIT, sub=START, rect_counter=0, all rect memories cleared to 0, hit register 0,
//   ready=0; color=DEFAULT_COLOR (zero-size rects never hit).
//  States: WAIT -copy_start-> COPY -last color word-> EXECUTE; EXECUTE holds until reset.
//   copy_start ignored outside WAIT. Reset mid-COPY aborts and clears, as above.
//  COPY sub-states cycle START,X,Y,W,H,COLOR (one word/cycle); mem_din ignored in START.
//   X: left=clamp(x,0,640); raw x latched.  Y: top=clamp(y,0,480); raw y latched.
//   W: right=clamp(raw_x+w,0,640).  H: bottom=clamp(raw_y+h,0,480). Sums wrap at 16 bits.
//   Clamp: signed value <0 -> 0, >limit -> limit, else low COORD_WIDTH bits.
//   COLOR: color stored; rect_counter++ (COLOR->START). Writes go to slot rect_counter.
//   Each rect costs 6 cycles; COPY lasts 6*RECT_COUNT cycles; on COLOR with rect_counter=RECT_COUNT-1
//   next state is EXECUTE, counter wraps to 0.
//  Hit test (per rect i, parallel): left<=x<right && top<=y<bottom (unsigned; half-open).
//   Empty/inverted rect (right<=left or bottom<=top) never hits.
//  Hit vector registered each cycle (all states); priority tree of log2(RECT_COUNT) 2:1 mux layers:
//   each pair selects upper index if its flag set, else lower; flag_out = OR of flags.
//  color = any_hit ? colors[winner] : DEFAULT_COLOR. Latency: coords at edge N -> color after edge N+1
//   (1 cycle). Color read combinationally from stored table, so works in any state (memory contents
//   during COPY are partial; consumers use ready).
//  Ties: higher index always wins. Coordinates beyond 640/480 simply miss clamped rects.
// CONFIGURATION
//  RECT_TREE_PIPELINE_EN defined: extra register after mux layer log2(RECT_COUNT)/2 (index + flag),
//   latency becomes 2 cycles; reset clears it. Undefined: tree fully combinational, latency 1.
// TESTING
//  Reset then copy_start, stream rect0=(10,20,30,40,16'hF800), others 0 -> ready after 6*64+1 cycles;
//   (10,20)->F800, (39,59)->F800, (40,20)->DEFAULT, (9,20)->DEFAULT.
//  Overlap: rect3=(0,0,100,100,16'h07E0), rect7=(50,50,100,100,16'h001F) -> (60,60)->001F, (10,10)->07E0.
//  Clamp: x=-5,w=20 -> left 0,right 15 -> (0,0) hits, (15,0) misses; x=700 -> empty, never hits;
//   y=470,h=50 -> bottom 480.
//  Latency: toggle coords each cycle, check color follows 1 cycle (2 with RECT_TREE_PIPELINE_EN).
//  Reset asserted mid-COPY (rect 20, sub W) -> ready=0, color=DEFAULT next sample; new copy_start reloads.
//  copy_start pulses during COPY/EXECUTE -> no state or counter change.

Source files
------------

// File: rtl/rect_raster_if.sv
// rect_raster_if: load stream, pixel query and color result of rect_raster_core.
interface rect_raster_if #(parameter int COORD_WIDTH = 10);
    logic                   copy_start;
    logic [COORD_WIDTH-1:0] x_coord;
    logic [COORD_WIDTH-1:0] y_coord;
    logic [15:0]            mem_din;
    logic                   ready;
    logic [15:0]            color;
    modport master (output copy_start, x_coord, y_coord, mem_din, input ready, color);
    modport slave  (input copy_start, x_coord, y_coord, mem_din, output ready, color);
endinterface

// File: rtl/rect_raster_core.sv
// rect_raster_core: loads clamped rectangles from a word stream and returns the top-most covering color per pixel.
// Define RECT_TREE_PIPELINE_EN to register the priority tree midway (2-cycle latency instead of 1).
module rect_raster_core #(
    parameter int          COORD_WIDTH      = 10,
    parameter int          RECT_COUNT       = 64,
    parameter int          RECT_COUNT_WIDTH = 6,
    parameter logic [15:0] DEFAULT_COLOR    = 16'h0000
) (
    input logic         clk,
    input logic         reset,
    rect_raster_if.slave bus
);
    localparam int W = RECT_COUNT_WIDTH;
`ifdef RECT_TREE_PIPELINE_EN
    localparam int PL = W / 2 + 1;
`else
    localparam int PL = 0;
`endif
    typedef enum logic [1:0] {WAIT, COPY, EXECUTE} state_t;
    typedef enum logic [2:0] {START, SX, SY, SW, SH, SCOLOR} sub_t;
    state_t state, state_n;
    sub_t sub, sub_n;
    logic [W-1:0] rect_counter, counter_n;
    logic signed [15:0] din, raw_x, raw_y;
    logic [COORD_WIDTH-1:0] left [RECT_COUNT];
    logic [COORD_WIDTH-1:0] top [RECT_COUNT];
    logic [COORD_WIDTH-1:0] right [RECT_COUNT];
    logic [COORD_WIDTH-1:0] bottom [RECT_COUNT];
    logic [15:0] colors [RECT_COUNT];
    logic [RECT_COUNT-1:0] hit, hit_q;

    assign din = bus.mem_din;

    function automatic logic [COORD_WIDTH-1:0] clamp(input logic signed [15:0] v, input logic signed [15:0] lim);
        return v[15] ? '0 : (v > lim) ? lim[COORD_WIDTH-1:0] : v[COORD_WIDTH-1:0];
    endfunction

    always_comb begin
        state_n   = state;
        sub_n     = sub;
        counter_n = rect_counter;
        if (state == WAIT && bus.copy_start) state_n = COPY;
        if (state == COPY) begin
            sub_n = (sub == SCOLOR) ? START : sub_t'(sub + 3'd1);
            if (sub == SCOLOR) begin
                counter_n = rect_counter + 1'b1;
                state_n   = (rect_counter == W'(RECT_COUNT - 1)) ? EXECUTE : COPY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= WAIT;
            sub          <= START;
            rect_counter <= '0;
        end else begin
            state        <= state_n;
            sub          <= sub_n;
            rect_counter <= counter_n;
        end

    // Right/bottom use the raw (unclamped) origin so a negative x/y still yields the true far edge.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            raw_x <= '0;
            raw_y <= '0;
            for (int i = 0; i < RECT_COUNT; i++) begin
                left[i]   <= '0;
                top[i]    <= '0;
                right[i]  <= '0;
                bottom[i] <= '0;
                colors[i] <= '0;
            end
        end else if (state == COPY) begin
            if (sub == SX) begin
                left[rect_counter] <= clamp(din, 16'sd640);
                raw_x              <= din;
            end
            if (sub == SY) begin
                top[rect_counter] <= clamp(din, 16'sd480);
                raw_y             <= din;
            end
            if (sub == SW) right[rect_counter] <= clamp(raw_x + din, 16'sd640);
            if (sub == SH) bottom[rect_counter] <= clamp(raw_y + din, 16'sd480);
            if (sub == SCOLOR) colors[rect_counter] <= bus.mem_din;
        end

    always_comb begin
        hit = '0;
        for (int i = 0; i < RECT_COUNT; i++)
            hit[i] = left[i] <= bus.x_coord && bus.x_coord < right[i] &&
                     top[i] <= bus.y_coord && bus.y_coord < bottom[i];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) hit_q <= '0;
        else hit_q <= hit;

    // Level l holds RECT_COUNT>>l candidates; each layer keeps the upper index when its flag is set.
    for (genvar l = 0; l <= W; l++) begin : g
        localparam int N = RECT_COUNT >> l;
        logic [W-1:0] idx [N];
        logic         flg [N];
        if (l == 0) begin : g_leaf
            for (genvar n = 0; n < N; n++) begin : g_n
                assign idx[n] = W'(n);
                assign flg[n] = hit_q[n];
            end
        end else begin : g_node
            logic [W-1:0] pi [2*N];
            logic         pf [2*N];
            if (l == PL) begin : g_reg
                always_ff @(posedge clk or posedge reset)
                    if (reset) begin
                        for (int k = 0; k < 2 * N; k++) begin
                            pi[k] <= '0;
                            pf[k] <= 1'b0;
                        end
                    end else begin
                        for (int k = 0; k < 2 * N; k++) begin
                            pi[k] <= g[l-1].idx[k];
                            pf[k] <= g[l-1].flg[k];
                        end
                    end
            end else begin : g_wire
                for (genvar k = 0; k < 2 * N; k++) begin : g_k
                    assign pi[k] = g[l-1].idx[k];
                    assign pf[k] = g[l-1].flg[k];
                end
            end
            for (genvar n = 0; n < N; n++) begin : g_n
                assign idx[n] = pf[2*n+1] ? pi[2*n+1] : pi[2*n];
                assign flg[n] = pf[2*n+1] | pf[2*n];
            end
        end
    end

    assign bus.ready = state == EXECUTE;
    assign bus.color = g[W].flg[0] ? colors[g[W].idx[0]] : DEFAULT_COLOR;
endmodule

// File: tb/tb_rect_raster_core.sv
// tb_rect_raster_core: directed and randomized rectangle loads checked against a per-pixel scan model.
module tb_rect_raster_core;
`ifdef RECT_TREE_PIPELINE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic signed [15:0] mx [64];
    logic signed [15:0] my [64];
    logic signed [15:0] mw [64];
    logic signed [15:0] mh [64];
    logic [15:0] mc [64];

    always #5 clk = ~clk;

    rect_raster_if bus ();
    rect_raster_core dut (.clk(clk), .reset(reset), .bus(bus.slave));

    function automatic int clampi(int v, int lim);
        return v < 0 ? 0 : (v > lim ? lim : v);
    endfunction

    // Scan from the highest index down; the first covering rectangle is the visible one.
    function automatic logic [15:0] model(int x, int y);
        for (int i = 63; i >= 0; i--) begin
            logic signed [15:0] ex, ey;
            ex = mx[i] + mw[i];
            ey = my[i] + mh[i];
            if (x >= clampi(mx[i], 640) && x < clampi(ex, 640) &&
                y >= clampi(my[i], 480) && y < clampi(ey, 480)) return mc[i];
        end
        return 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 64; i++) begin
            mx[i] = 0; my[i] = 0; mw[i] = 0; mh[i] = 0; mc[i] = 0;
        end
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input logic [15:0] c);
        mx[i] = 16'(x); my[i] = 16'(y); mw[i] = 16'(w); mh[i] = 16'(h); mc[i] = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clr();
    endtask

    // Streams all 64 model rectangles; copy_start toggles randomly throughout and must be ignored.
    task automatic load(input int abort_rect);
        logic [15:0] words [6];
        @(posedge clk);
        #1 bus.copy_start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            words = '{16'($urandom), mx[i], my[i], mw[i], mh[i], mc[i]};
            for (int s = 0; s < 6; s++) begin
                if (i == abort_rect && s == 3) begin
                    reset = 1'b1;
                    bus.copy_start = 1'b0;
                    return;
                end
                if (i == 63 && s == 5) chk("ready_before_last", 16'(bus.ready), 16'd0);
                bus.mem_din = words[s];
                bus.copy_start = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        bus.copy_start = 1'b0;
    endtask

    task automatic px(input string tag, input int x, input int y, input logic [15:0] exp);
        bus.x_coord = 10'(x);
        bus.y_coord = 10'(y);
        repeat (LAT) @(posedge clk);
        #1 chk(tag, bus.color, exp);
    endtask

    initial begin
        logic [15:0] ea [16];
        int x, y;
        bus.copy_start = 1'b0;
        bus.x_coord = '0;
        bus.y_coord = '0;
        bus.mem_din = '0;
        clr();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_ready", 16'(bus.ready), 16'd0);
        px("reset_color", 0, 0, 16'h0000);

        set_rect(0, 10, 20, 30, 40, 16'hF800);
        load(-1);
        chk("ready_after_load", 16'(bus.ready), 16'd1);
        px("r0_topleft", 10, 20, 16'hF800);
        px("r0_botright", 39, 59, 16'hF800);
        px("r0_right_edge", 40, 20, 16'h0000);
        px("r0_left_edge", 9, 20, 16'h0000);

        for (int k = 0; k < 16; k++) begin
            bus.x_coord = (k % 2) ? 10'd40 : 10'd10;
            bus.y_coord = 10'd20;
            ea[k] = (k % 2) ? 16'h0000 : 16'hF800;
            @(posedge clk);
            #1;
            if (k + 1 >= LAT) chk("latency", bus.color, ea[k+1-LAT]);
        end

        bus.copy_start = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.copy_start = 1'b0;
        chk("exec_ignores_start", 16'(bus.ready), 16'd1);
        px("exec_keeps_table", 10, 20, 16'hF800);

        do_reset();
        set_rect(3, 0, 0, 100, 100, 16'h07E0);
        set_rect(7, 50, 50, 100, 100, 16'h001F);
        set_rect(10, -5, 0, 20, 10, 16'h1234);
        set_rect(11, 700, 0, 50, 50, 16'h5555);
        set_rect(12, 600, 470, 100, 50, 16'hABCD);
        load(-1);
        px("overlap_hi", 60, 60, 16'h001F);
        px("overlap_lo", 10, 10, 16'h07E0);
        px("overlap_far", 149, 149, 16'h001F);
        px("overlap_out", 150, 150, 16'h0000);
        px("clamp_left", 0, 0, 16'h1234);
        px("clamp_right", 15, 0, 16'h07E0);
        px("clamp_x700", 700, 5, 16'h0000);
        px("clamp_bottom_in", 620, 479, 16'hABCD);
        px("clamp_bottom_out", 620, 480, 16'h0000);

        do_reset();
        for (int i = 0; i < 64; i++)
            set_rect(i, $urandom_range(0, 600), $urandom_range(0, 400), $urandom_range(1, 200), $urandom_range(1, 200), 16'($urandom));
        set_rect(0, 10, 20, 30, 40, 16'hF800);
        load(20);
        #1 chk("abort_ready", 16'(bus.ready), 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        clr();
        px("abort_color", 10, 20, 16'h0000);
        chk("abort_ready_held", 16'(bus.ready), 16'd0);

        for (int i = 0; i < 64; i++)
            set_rect(i, int'($urandom_range(0, 800)) - 60, int'($urandom_range(0, 600)) - 60,
                     int'($urandom_range(0, 320)) - 20, int'($urandom_range(0, 320)) - 20, 16'($urandom));
        set_rect(5, 32000, 0, 1000, 100, 16'hBEEF);
        load(-1);
        chk("reload_ready", 16'(bus.ready), 16'd1);
        for (int k = 0; k < 200; k++) begin
            x = (k % 4 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 660));
            y = (k % 4 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 500));
            px("random_px", x, y, model(x, y));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
